// File: rtl/loader_pkg.sv
// loader_pkg: loader FSM state encoding, bytes per word and length-byte mask
package loader_pkg;
  typedef enum logic [2:0] {IDLE, GET_LEN, GET_BYTE, WRITE, FINISH} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [4:0] LEN_MASK = 5'h1F;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs bytes little-endian into a word (clk, reset, clear, clear_sum, shift, byte_data -> word, word_full=next byte completes word, checksum)
module byte_packer import loader_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  clear_sum,
  input  logic                  shift,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full,
  output logic [7:0]            checksum
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [CW-1:0] count;
  assign word_full = count == CW'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count    <= '0;
      word     <= '0;
      checksum <= '0;
    end else begin
      if (clear) begin
        count <= '0;
        word  <= '0;
      end else if (shift) begin
        count <= count + 1'b1;
        word  <= {byte_data, word[DATA_WIDTH-1:8]};
      end
      if (clear_sum) checksum <= '0;
      else if (shift) checksum <= checksum ^ byte_data;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a byte-stream image into program memory, stalls/restarts the CPU and muxes the memory address (start, byte_valid/data/ready, cpu_address/stall/restart, mem_*, load_busy/done/checksum)
module program_loader import loader_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic                  cpu_stall,
  output logic                  cpu_restart,
  output logic [ADDR_WIDTH-1:0] mem_byte_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [7:0]            load_checksum
);
  loader_state_t state;
  logic [ADDR_WIDTH-1:0] word_index, word_last;
  logic xfer, word_full;
  assign byte_ready       = state == GET_LEN || state == GET_BYTE;
  assign xfer             = byte_valid && byte_ready;
  assign load_busy        = state != IDLE;
  assign cpu_stall        = load_busy;
  assign load_done        = state == FINISH;
  assign cpu_restart      = load_done;
  assign mem_write_enable = state == WRITE;
  assign mem_byte_address = state == IDLE ? cpu_address : word_index;
  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     ((xfer && state == GET_LEN) || state == WRITE),
    .clear_sum (xfer && state == GET_LEN),
    .shift     (xfer && state == GET_BYTE),
    .byte_data (byte_data),
    .word      (mem_write_data),
    .word_full (word_full),
    .checksum  (load_checksum)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      word_index <= '0;
      word_last  <= '0;
    end else
      case (state)
        IDLE:     if (start) state <= GET_LEN;
        GET_LEN:
          if (byte_valid) begin
            word_last  <= ADDR_WIDTH'(byte_data[4:0] & LEN_MASK);
            word_index <= '0;
            state      <= GET_BYTE;
          end
        GET_BYTE: if (byte_valid && word_full) state <= WRITE;
        WRITE:
          if (word_index == word_last) state <= FINISH;
          else begin
            word_index <= word_index + 1'b1;
            state      <= GET_BYTE;
          end
        FINISH:   state <= IDLE;
        default:  state <= IDLE;
      endcase
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scoreboard bench for program_loader
module tb_program_loader;
  logic clk = 0, reset, start, byte_valid;
  logic [7:0] byte_data, load_checksum;
  logic [4:0] cpu_address, mem_byte_address;
  logic byte_ready, cpu_stall, cpu_restart, mem_write_enable, load_busy, load_done;
  logic [31:0] mem_write_data;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  logic [31:0] img [32];
  int errors = 0, checks = 0, cyc = 0;
  int done_count = 0, restart_count = 0, wr_count = 0, done_cyc = 0, wr_cyc = 0;
  logic [7:0] exp_sum;
  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .cpu_address(cpu_address), .cpu_stall(cpu_stall),
    .cpu_restart(cpu_restart), .mem_byte_address(mem_byte_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .load_busy(load_busy), .load_done(load_done), .load_checksum(load_checksum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (mem_write_enable) begin
      wr_t e;
      chk("ready_in_write", 32'(byte_ready), 0);
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_byte_address), 32'(e.a));
        chk("write_data", mem_write_data, e.d);
      end
      wr_cyc = cyc;
      wr_count++;
    end
    if (load_done) begin
      chk("restart_with_done", 32'(cpu_restart), 1);
      chk("stall_in_finish", 32'(cpu_stall), 1);
      done_cyc = cyc;
      done_count++;
    end
    if (cpu_restart) restart_count++;
  end
  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    int n = 0;
    repeat (gap) begin
      byte_valid = 0;
      @(posedge clk); #1;
    end
    byte_valid = 1;
    byte_data = b;
    do begin
      @(negedge clk); ok = byte_ready; n++;
      @(posedge clk); #1;
    end while (!ok && n < 200);
    if (!ok) chk("byte_timeout", 32'(ok), 1);
    byte_valid = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input int prev);
    int n = 0;
    while (done_count == prev && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("done_seen", 32'(done_count - prev), 1);
  endtask
  task automatic push_word(input int i);
    exp_q.push_back({5'(i), img[i]});
    for (int j = 0; j < 4; j++) exp_sum ^= img[i][8*j +: 8];
  endtask
  initial begin
    int d0, r0, w0, sc;
    reset = 1; start = 0; byte_valid = 0; byte_data = 0; cpu_address = 5'd7;
    #1;
    chk("rst_addr", 32'(mem_byte_address), 7);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_busy", 32'(load_busy), 0);
    chk("rst_we", 32'(mem_write_enable), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_restart", 32'(cpu_restart), 0);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_sum", 32'(load_checksum), 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_addr", 32'(mem_byte_address), 7);
    chk("idle_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1;
    // single word 0x00A00513
    img[0] = 32'h00A00513; exp_sum = 0; d0 = done_count;
    push_word(0);
    sc = cyc;
    pulse_start();
    chk("busy_after_start", 32'(cpu_stall), 1);
    send(8'h00, 0); send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
    wait_done(d0);
    chk("stall_low_after_done", 32'(cpu_stall), 0);
    chk("busy_low_after_done", 32'(load_busy), 0);
    chk("done_after_write", 32'(done_cyc - wr_cyc), 1);
    chk("load_time_k1", 32'(done_cyc - sc), 7);
    chk("sum_single", 32'(load_checksum), 32'hB6);
    chk("q_empty_single", 32'(exp_q.size()), 0);
    // full 32-word load with random gaps
    exp_sum = 0; d0 = done_count; w0 = wr_count;
    pulse_start();
    send(8'hFF, $urandom_range(0, 3));
    for (int i = 0; i < 32; i++) begin
      img[i] = 32'hCAFE0000 | i;
      push_word(i);
      for (int j = 0; j < 4; j++) send(img[i][8*j +: 8], $urandom_range(0, 3));
    end
    wait_done(d0);
    chk("full_writes", 32'(wr_count - w0), 32);
    chk("q_empty_full", 32'(exp_q.size()), 0);
    chk("sum_full", 32'(load_checksum), 32'(exp_sum));
    // start pulses during GET_BYTE and WRITE are ignored
    exp_sum = 0; d0 = done_count; w0 = wr_count;
    img[0] = 32'h11223344; img[1] = 32'h55667788;
    pulse_start();
    send(8'h01, 0);
    push_word(0); push_word(1);
    send(img[0][7:0], 0);
    start = 1;
    send(img[0][15:8], 0);
    start = 0;
    send(img[0][23:16], 0); send(img[0][31:24], 0);
    chk("in_write", 32'(mem_write_enable), 1);
    pulse_start();
    for (int j = 0; j < 4; j++) send(img[1][8*j +: 8], 0);
    wait_done(d0);
    repeat (10) @(posedge clk);
    #1;
    chk("single_done", 32'(done_count - d0), 1);
    chk("idle_after_ignored", 32'(load_busy), 0);
    chk("ignored_writes", 32'(wr_count - w0), 2);
    chk("sum_ignored", 32'(load_checksum), 32'(exp_sum));
    // reset after 2 of 3 words
    exp_sum = 0; r0 = restart_count; w0 = wr_count;
    img[0] = 32'hA0A0A0A0; img[1] = 32'hB1B1B1B1; img[2] = 32'hC2C2C2C2;
    pulse_start();
    send(8'h02, 0);
    push_word(0); push_word(1);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) send(img[i][8*j +: 8], 0);
    send(img[2][7:0], 0); send(img[2][15:8], 0);
    #3 reset = 1;
    #1;
    chk("rst_mid_busy", 32'(load_busy), 0);
    chk("rst_mid_stall", 32'(cpu_stall), 0);
    chk("rst_mid_addr", 32'(mem_byte_address), 7);
    @(posedge clk); #1 reset = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_writes", 32'(wr_count - w0), 2);
    chk("rst_mid_q", 32'(exp_q.size()), 0);
    chk("rst_mid_no_restart", 32'(restart_count - r0), 0);
    // byte_valid held in IDLE: first accepted byte is the length
    exp_sum = 0; d0 = done_count; w0 = wr_count;
    byte_valid = 1; byte_data = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_not_ready", 32'(byte_ready), 0);
      @(posedge clk); #1;
    end
    img[0] = 32'h0BADF00D; img[1] = 32'hFEEDBEEF;
    pulse_start();
    send(8'h01, 0);
    push_word(0); push_word(1);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) send(img[i][8*j +: 8], 0);
    wait_done(d0);
    chk("held_writes", 32'(wr_count - w0), 2);
    chk("held_sum", 32'(load_checksum), 32'(exp_sum));
    chk("held_q", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
